// File: rtl/tdm_demux4_pkg.sv
// Shared types and helpers for the 4-slot TDM link.
// slot_lane encodes the bit-swapped slot-to-lane wiring of the upstream mux.
package tdm_pkg;

  typedef enum logic {IDLE, RUN} tdm_state_t;

  localparam int SLOTS = 4;

  function automatic logic [1:0] slot_lane(logic [1:0] s);
    return {s[0], s[1]};
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Link-side signal bundle for the TDM demultiplexer.
// The consumer drives en/sync/din; the demux drives slot select and frame outputs.
interface tdm_demux4_if #(
  parameter int W = 1
);
  logic           en;
  logic           sync;
  logic [W-1:0]   din;
  logic [1:0]     sel;
  logic [4*W-1:0] q;
  logic           valid;
  logic           frame_err;
  logic           locked;

  modport master (
    output en, sync, din,
    input  sel, q, valid, frame_err, locked
  );

  modport slave (
    input  en, sync, din,
    output sel, q, valid, frame_err, locked
  );
endinterface

// File: rtl/tdm_demux4_slot_ctr.sv
// 2-bit wrapping slot counter with a synchronous load-to-1 used on frame restart.
// tc flags the cycle in which the last slot is consumed.
module tdm_slot_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_load1,
  output logic [1:0] o_cnt,
  output logic       o_tc
);

  logic [1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= 2'd1;
    end else if (i_en) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == 2'd3) && i_en;

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side 4-slot TDM demultiplexer: drives the upstream mux select and
// collects one sample per slot into a shadow frame, publishing it on completion.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic          hz100,
  input  logic          reset,
  tdm_demux4_if.slave   bus
);

  tdm_state_t         r_state;
  logic [W-1:0]       r_shadow [SLOTS];
  logic [SLOTS*W-1:0] r_q;
  logic               r_valid;
  logic               r_frame_err;
  logic               r_locked;

  logic [1:0]         w_sel;
  logic               w_tc;
  logic               w_run;
  logic               w_load1;
  logic               w_ctr_en;

  assign w_run    = (r_state == RUN);
  // Any qualified sync restarts the slot sequence at 1, in IDLE or mid-frame.
  assign w_load1  = bus.en && bus.sync;
  assign w_ctr_en = bus.en && !bus.sync && w_run;

  tdm_slot_ctr u_ctr (
    .clk     (hz100),
    .rst_n   (reset),
    .i_en    (w_ctr_en),
    .i_load1 (w_load1),
    .o_cnt   (w_sel),
    .o_tc    (w_tc)
  );

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_locked    <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load1) begin
            r_shadow[0] <= bus.din;
            r_state     <= RUN;
            r_locked    <= 1'b1;
          end
        end
        RUN: begin
          if (w_load1) begin
            // Sync outside slot 0 drops the partial frame and restarts it.
            if (w_sel != 2'd0) begin
              r_frame_err <= 1'b1;
              for (int k = 1; k < SLOTS; k++) begin
                r_shadow[k] <= '0;
              end
            end
            r_shadow[0] <= bus.din;
          end else if (w_tc) begin
            r_q     <= {bus.din, r_shadow[2], r_shadow[1], r_shadow[0]};
            r_valid <= 1'b1;
          end else if (w_ctr_en) begin
            r_shadow[slot_lane(w_sel)] <= bus.din;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel       = w_sel;
  assign bus.q         = r_q;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.locked    = r_locked;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (W=1) with a queue scoreboard of completed frames.
module tb_tdm_demux4;

  logic       hz100 = 1'b0;
  logic       reset;
  logic       lb;
  logic [3:0] lb_d;
  logic [0:0] din_man;

  int total  = 0;
  int bad    = 0;
  int nvalid = 0;
  int nferr  = 0;

  logic [3:0] exp_q[$];
  logic [3:0] last_q = 4'd0;

  tdm_demux4_if #(.W(1)) bus ();

  tdm_demux4 #(.W(1)) dut (
    .hz100 (hz100),
    .reset (reset),
    .bus   (bus)
  );

  always #5 hz100 = ~hz100;

  // Upstream mux4to1 is bit-swapped: sel s selects d[{s[0],s[1]}].
  always_comb bus.din = lb ? lb_d[{bus.sel[0], bus.sel[1]}] : din_man;

  // v[s] is the sample sent in slot s; slot s lands in lane {s[0],s[1]}.
  function automatic logic [3:0] map_q(input logic [3:0] v);
    return {v[3], v[1], v[2], v[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] e;
    @(posedge hz100);
    #1;
    chk("valid_ferr_exclusive", 32'(bus.valid & bus.frame_err), 32'd0);
    if (bus.frame_err) nferr++;
    if (bus.valid) begin
      nvalid++;
      if (exp_q.size() == 0) begin
        chk("valid_unexpected", 32'(bus.valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("frame_q", 32'(bus.q), 32'(e));
        last_q = e;
      end
    end
  endtask

  task automatic send_frame(input logic [3:0] v, input bit do_sync, input int max_gap);
    for (int s = 0; s < 4; s++) begin
      chk("sel_slot", 32'(bus.sel), 32'(s));
      bus.en   = 1'b1;
      bus.sync = (s == 0) && do_sync;
      din_man  = v[s];
      if (s == 3) exp_q.push_back(map_q(v));
      tick();
      if (s == 0) chk("locked", 32'(bus.locked), 32'd1);
      bus.en   = 1'b0;
      bus.sync = 1'b0;
      if (max_gap > 0) begin
        int g;
        g = int'($urandom_range(max_gap, 0));
        for (int j = 0; j < g; j++) begin
          tick();
          chk("sel_frozen", 32'(bus.sel), 32'((s + 1) % 4));
        end
      end
    end
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    lb       = 1'b0;
    lb_d     = 4'd0;
    din_man  = 1'b1;
    reset    = 1'b0;
    bus.en   = 1'b1;
    bus.sync = 1'b1;

    // reset held with en/sync asserted
    repeat (3) tick();
    chk("reset_q", 32'(bus.q), 32'd0);
    chk("reset_sel", 32'(bus.sel), 32'd0);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_ferr", 32'(bus.frame_err), 32'd0);
    reset    = 1'b1;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    tick();
    chk("idle_locked", 32'(bus.locked), 32'd0);

    // lane mapping, one frame each starting with sync
    send_frame(4'b0001, 1'b1, 0);
    chk("map_slot0", 32'(last_q), 32'h1);
    send_frame(4'b0010, 1'b1, 0);
    chk("map_slot1", 32'(last_q), 32'h4);
    send_frame(4'b0100, 1'b1, 0);
    chk("map_slot2", 32'(last_q), 32'h2);
    send_frame(4'b1000, 1'b1, 0);
    chk("map_slot3", 32'(last_q), 32'h8);
    chk("valid_count_map", 32'(nvalid), 32'd4);

    // loopback through the swapped mux, en held high, single sync
    lb   = 1'b1;
    lb_d = 4'b1011;
    for (int i = 0; i < 20; i++) begin
      chk("lb_sel", 32'(bus.sel), 32'(i % 4));
      bus.en   = 1'b1;
      bus.sync = (i == 0);
      if (i % 4 == 3) exp_q.push_back(4'b1011);
      tick();
      chk("lb_valid", 32'(bus.valid), 32'(i % 4 == 3));
    end
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    lb       = 1'b0;
    tick();
    chk("lb_drained", 32'(exp_q.size()), 32'd0);
    chk("valid_count_lb", 32'(nvalid), 32'd9);

    // stalls between slots, frames continue without sync
    repeat (4) send_frame(4'($urandom), 1'b0, 3);

    // mid-frame sync at slot 2
    bus.en   = 1'b1;
    bus.sync = 1'b0;
    din_man  = 1'b1;
    tick();
    tick();
    chk("ms_sel_before", 32'(bus.sel), 32'd2);
    bus.sync = 1'b1;
    tick();
    chk("ms_ferr", 32'(bus.frame_err), 32'd1);
    chk("ms_sel_restart", 32'(bus.sel), 32'd1);
    chk("ms_q_held", 32'(bus.q), 32'(last_q));
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    tick();
    chk("ms_ferr_pulse", 32'(bus.frame_err), 32'd0);
    chk("ms_q_held2", 32'(bus.q), 32'(last_q));
    begin
      logic [3:0] v;
      v = 4'b1101;
      for (int s = 1; s < 4; s++) begin
        chk("ms_sel_seq", 32'(bus.sel), 32'(s));
        bus.en  = 1'b1;
        din_man = v[s];
        if (s == 3) exp_q.push_back(map_q(v));
        tick();
      end
      bus.en = 1'b0;
      tick();
      chk("ms_drained", 32'(exp_q.size()), 32'd0);
      chk("ms_frame", 32'(last_q), 32'hB);
      chk("ms_ferr_count", 32'(nferr), 32'd1);
    end

    // asynchronous reset mid-frame
    bus.en   = 1'b1;
    bus.sync = 1'b1;
    din_man  = 1'b1;
    tick();
    bus.sync = 1'b0;
    tick();
    chk("rm_sel_before", 32'(bus.sel), 32'd2);
    reset = 1'b0;
    #2;
    chk("rm_q", 32'(bus.q), 32'd0);
    chk("rm_sel", 32'(bus.sel), 32'd0);
    chk("rm_locked", 32'(bus.locked), 32'd0);
    tick();
    reset    = 1'b1;
    bus.en   = 1'b1;
    bus.sync = 1'b0;
    repeat (4) begin
      tick();
      chk("rm_idle_sel", 32'(bus.sel), 32'd0);
      chk("rm_idle_valid", 32'(bus.valid), 32'd0);
      chk("rm_idle_locked", 32'(bus.locked), 32'd0);
    end
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
